// File: rtl/arbiter_puf_ctrl.sv
// arbiter_puf_ctrl
// Sequences challenges into an arbiter PUF and collects majority-voted response bits.
// A seed request expands into RESP_W challenges through a Fibonacci LFSR. Each
// challenge is raced VOTES times. Every race is an ARM phase followed by a FIRE
// phase and one SAMPLE cycle. The voted word and a count of non-unanimous bits are
// returned over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   req_valid_i/req_ready_o         seed request handshake
//   req_seed_i   [CHAL_W]           initial challenge (0 is replaced by all-ones)
//   resp_valid_o/resp_ready_i       response handshake
//   resp_data_o  [RESP_W]           voted response, bit k from the k-th challenge
//   resp_unstable_o                 number of bits whose votes disagreed
//   race_o       [2]                race launch to the PUF
//   challenge_o  [CHAL_W]           challenge to the PUF
//   puf_resp_i                      PUF arbiter output, asynchronous to clk_i
module arbiter_puf_ctrl #(
    parameter int unsigned        CHAL_W        = 64,
    parameter int unsigned        RESP_W        = 32,
    parameter logic [CHAL_W-1:0]  TAPS          = 64'hD800_0000_0000_0000,
    parameter int unsigned        SETTLE_CYCLES = 4,
    parameter int unsigned        VOTES         = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [CHAL_W-1:0]            req_seed_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [RESP_W-1:0]            resp_data_o,
    output logic [$clog2(RESP_W+1)-1:0]  resp_unstable_o,
    output logic [1:0]                   race_o,
    output logic [CHAL_W-1:0]            challenge_o,
    input  logic                         puf_resp_i
);

    localparam int unsigned IDX_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int unsigned UNS_W  = $clog2(RESP_W + 1);
    localparam int unsigned VOTE_W = $clog2(VOTES + 1);
    localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 2);

    localparam logic [CNT_W-1:0]  ARM_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    // FIRE is extended by two cycles so the synchronizer output reflects this race.
    localparam logic [CNT_W-1:0]  FIRE_LAST = CNT_W'(SETTLE_CYCLES + 1);
    localparam logic [VOTE_W-1:0] VOTES_C   = VOTE_W'(VOTES);
    localparam logic [VOTE_W-1:0] HALF_C    = VOTE_W'(VOTES / 2);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(RESP_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          w_race_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [VOTE_W-1:0]   r_votes;
    logic [VOTE_W-1:0]   r_ones;
    logic [VOTE_W-1:0]   w_votes_inc;
    logic [VOTE_W-1:0]   w_ones_inc;
    logic                w_vote_more;
    logic                w_last_idx;
    logic [CHAL_W-1:0]   r_chal;
    logic [RESP_W-1:0]   r_data;
    logic [UNS_W-1:0]    r_uns;
    logic [1:0]          r_race;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic                r_sync1;
    logic                r_sync2;

    assign w_votes_inc = r_votes + VOTE_W'(1);
    assign w_ones_inc  = r_ones + VOTE_W'(r_sync2);
    assign w_vote_more = (w_votes_inc < VOTES_C);
    assign w_last_idx  = (r_idx == IDX_LAST);

    assign req_ready_o     = r_req_ready;
    assign resp_valid_o    = r_resp_valid;
    assign resp_data_o     = r_data;
    assign resp_unstable_o = r_uns;
    assign race_o          = r_race;
    assign challenge_o     = r_chal;

    // Two-flop synchronizer for the asynchronous arbiter output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= puf_resp_i;
            r_sync2 <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_next     = r_state;
        w_race_nxt = 2'b00;
        case (r_state)
            S_IDLE:   if (req_valid_i) w_next = S_ARM;
            S_ARM:    if (r_cnt == ARM_LAST) w_next = S_FIRE;
            S_FIRE:   if (r_cnt == FIRE_LAST) w_next = S_SAMPLE;
            S_SAMPLE: begin
                if (w_vote_more || !w_last_idx) w_next = S_ARM;
                else                            w_next = S_DONE;
            end
            S_DONE:   if (resp_ready_i) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_next == S_FIRE) w_race_nxt = 2'b11;
    end

    // Registered outputs, phase counter and vote datapath.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_race       <= 2'b00;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_votes      <= '0;
            r_ones       <= '0;
            r_chal       <= '0;
            r_data       <= '0;
            r_uns        <= '0;
        end else begin
            r_race       <= w_race_nxt;
            r_req_ready  <= (w_next == S_IDLE);
            r_resp_valid <= (w_next == S_DONE);
            // Phase counter restarts on every state change.
            r_cnt        <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        // An all-zero LFSR state would lock up, so substitute all-ones.
                        r_chal  <= (req_seed_i == '0) ? '1 : req_seed_i;
                        r_idx   <= '0;
                        r_votes <= '0;
                        r_ones  <= '0;
                        r_data  <= '0;
                        r_uns   <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (w_vote_more) begin
                        r_votes <= w_votes_inc;
                        r_ones  <= w_ones_inc;
                    end else begin
                        r_data[r_idx] <= (w_ones_inc > HALF_C);
                        if ((w_ones_inc != '0) && (w_ones_inc != VOTES_C)) begin
                            r_uns <= r_uns + UNS_W'(1);
                        end
                        r_votes <= '0;
                        r_ones  <= '0;
                        r_chal  <= {r_chal[CHAL_W-2:0], ^(r_chal & TAPS)};
                        if (!w_last_idx) r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// Self-checking bench for arbiter_puf_ctrl with a small configuration and a stub PUF.
module tb_arbiter_puf_ctrl;

    localparam int unsigned CW  = 8;
    localparam int unsigned RW  = 4;
    localparam int unsigned SC  = 1;
    localparam int unsigned VT  = 3;
    localparam int unsigned UW  = $clog2(RW + 1);
    localparam int unsigned LAT = RW * VT * (2 * SC + 3);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_seed;
    logic          resp_valid;
    logic          resp_ready;
    logic [RW-1:0] resp_data;
    logic [UW-1:0] resp_uns;
    logic [1:0]    race;
    logic [CW-1:0] chal;
    logic          puf_resp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    arbiter_puf_ctrl #(
        .CHAL_W(CW), .RESP_W(RW), .TAPS(8'hB8), .SETTLE_CYCLES(SC), .VOTES(VT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_seed_i(req_seed),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_unstable_o(resp_uns),
        .race_o(race), .challenge_o(chal), .puf_resp_i(puf_resp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stub PUF: mode 0 -> chal[0], mode 1 -> chal[7], mode 2 -> 1,0,1 per FIRE.
    int mode      = 0;
    int fire_cnt  = 0;
    int fire_base = 0;
    always @(posedge race[0]) fire_cnt <= fire_cnt + 1;
    always_comb begin
        case (mode)
            0:       puf_resp = chal[0];
            1:       puf_resp = chal[7];
            default: puf_resp = (((fire_cnt - fire_base - 1) % 3) != 1);
        endcase
    end

    // Race waveform monitor: FIRE lasts SC+2 cycles and the challenge holds throughout.
    logic          mon_en = 1'b0;
    int            run_len = 0;
    logic [CW-1:0] run_chal;
    logic [CW-1:0] fire_log[$];
    always @(negedge clk) begin
        if (!mon_en) begin
            run_len = 0;
        end else if (race == 2'b11) begin
            if (run_len == 0) begin
                run_chal = chal;
                fire_log.push_back(chal);
            end else begin
                check("chal_stable", 32'(chal), 32'(run_chal));
            end
            run_len++;
        end else begin
            if (run_len != 0) check("fire_len", 32'(run_len), 32'(SC + 2));
            run_len = 0;
        end
    end

    typedef struct {
        logic [RW-1:0] d;
        logic [UW-1:0] u;
    } exp_t;
    exp_t sb[$];

    // Drive a request from a negedge; returns just after the accepting edge.
    task automatic send_req(input logic [CW-1:0] seed);
        bit ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_seed  = seed;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_accept", 32'(ok), 32'd1);
        #1 req_valid = 1'b0;
    endtask

    // Called just after the accepting edge: checks latency and the popped expectation.
    task automatic wait_resp(input bit do_hs);
        int   n = 0;
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < LAT + 40; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("resp_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(LAT));
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("resp_data", 32'(resp_data), 32'(e.d));
            check("resp_unstable", 32'(resp_uns), 32'(e.u));
        end
        if (do_hs) begin
            @(posedge clk);
            #1;
            check("ready_after_hs", 32'(req_ready), 32'd1);
            check("valid_after_hs", 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        int            lb;
        int            bad;
        int            pulses;
        logic [RW-1:0] hd;
        logic [UW-1:0] hu;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_seed   = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_race", 32'(race), 32'd0);
        check("rst_chal", 32'(chal), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_data", 32'(resp_data), 32'd0);
        check("rst_uns", 32'(resp_uns), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        mon_en = 1'b1;

        // Seed 01, stub = chal[0].
        mode = 0;
        lb = fire_log.size();
        sb.push_back('{d: 4'b0001, u: '0});
        send_req(8'h01);
        wait_resp(1'b1);
        check("chal_b0", 32'(fire_log[lb + 0]), 32'h01);
        check("chal_b1", 32'(fire_log[lb + 3]), 32'h02);
        check("chal_b2", 32'(fire_log[lb + 6]), 32'h04);
        check("chal_b3", 32'(fire_log[lb + 9]), 32'h08);

        // Seed 00 becomes all-ones, stub = chal[7].
        mode = 1;
        lb = fire_log.size();
        sb.push_back('{d: 4'b1111, u: '0});
        send_req(8'h00);
        wait_resp(1'b1);
        check("chal_z0", 32'(fire_log[lb + 0]), 32'hFF);
        check("chal_z1", 32'(fire_log[lb + 3]), 32'hFE);
        check("chal_z2", 32'(fire_log[lb + 6]), 32'hFC);
        check("chal_z3", 32'(fire_log[lb + 9]), 32'hF8);

        // Toggling stub: every bit votes 2-of-3.
        fire_base = fire_cnt;
        mode = 2;
        sb.push_back('{d: 4'b1111, u: UW'(4)});
        send_req(8'h01);
        wait_resp(1'b1);

        // Back-pressure: output held, new request ignored until the handshake.
        mode = 0;
        resp_ready = 1'b0;
        sb.push_back('{d: 4'b0001, u: '0});
        send_req(8'h01);
        wait_resp(1'b0);
        hd = resp_data;
        hu = resp_uns;
        @(negedge clk);
        req_valid = 1'b1;
        req_seed  = 8'h80;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (resp_data !== hd || resp_uns !== hu || req_ready !== 1'b0 || resp_valid !== 1'b1)
                bad++;
        end
        check("hold_stable", 32'(bad), 32'd0);
        @(negedge clk);
        resp_ready = 1'b1;
        sb.push_back('{d: 4'b0010, u: '0});
        @(posedge clk);
        #1;
        check("hs_ready", 32'(req_ready), 32'd1);
        check("hs_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("accept_next", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        wait_resp(1'b1);

        // Reset during the FIRE of bit 2 aborts without a clock edge.
        mon_en = 1'b0;
        mode = 0;
        fire_base = fire_cnt;
        send_req(8'h01);
        bad = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((fire_cnt - fire_base) >= 7 && race == 2'b11) begin
                bad = 0;
                break;
            end
        end
        check("reach_bit2", 32'(bad), 32'd0);
        check("partial_data", 32'(resp_data), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("abort_race", 32'(race), 32'd0);
        check("abort_chal", 32'(chal), 32'd0);
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_data", 32'(resp_data), 32'd0);
        check("abort_uns", 32'(resp_uns), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("no_valid_after_abort", 32'(pulses), 32'd0);

        // Fresh request after the abort.
        mon_en = 1'b1;
        mode = 1;
        sb.push_back('{d: 4'b1111, u: '0});
        send_req(8'h00);
        wait_resp(1'b1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
